pio_poll_master: RTL
====================

Name: pio_poll_master

Overview:
- Avalon-MM read master that periodically polls a read-only PIO input slave.
- The slave presents input data at address 0 with fixed read latency 1, since its readdata is registered.
- The block detects value changes against the last sample and queues each new value in a small event FIFO.
- It exposes the FIFO as a valid/ready stream plus a level interrupt, so software or stream logic gets change events instead of busy-polling.

Parameters:
- DATA_W, 17: width of the sampled input field, readdata[DATA_W-1:0]; 1..32.
- ADDR_W, 2: width of the master address bus.
- POLL_DIV, 1000: idle cycles between polls; must be >= 1.
- FIFO_DEPTH, 4: event FIFO entries; must be a power of 2 and >= 2.

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- enable  in  1  polling enable.
- avm_address  out  ADDR_W  master address; always 0.
- avm_read  out  1  read strobe, one cycle per poll.
- avm_readdata  in  32  slave read data, valid the cycle after avm_read.
- evt_data  out  DATA_W  head-of-FIFO changed value.
- evt_valid  out  1  FIFO non-empty.
- evt_ready  in  1  consumer accepts the head entry when evt_valid && evt_ready.
- irq  out  1  level interrupt, equal to evt_valid.
- overflow  out  1  sticky flag: a change was dropped because the FIFO was full.
- clr_overflow  in  1  synchronous clear of overflow.

Behaviour:
- Reset values: avm_read=0, avm_address=0, evt_valid=0, evt_data=0, irq=0, overflow=0. FSM in IDLE, poll counter=0, FIFO empty, primed=0, last=0.
- Reset takes effect immediately when reset_n is asserted, including mid-poll and with a non-empty FIFO. All state returns to reset values and queued events are lost.
- All outputs are registered or derived from registers; there is no combinational path from inputs to outputs.
- FSM states: IDLE, READ, CAP.
- IDLE:
  - While enable=1, the counter increments each cycle.
  - When counter==POLL_DIV-1 and enable=1, the next state is READ and the counter resets to 0.
  - While enable=0, the counter is held at 0 and primed is cleared.
- READ: avm_read=1 for exactly this one cycle; next state is CAP unconditionally.
- CAP:
  - avm_read=0.
  - The block samples s = avm_readdata[DATA_W-1:0]; upper bits are ignored.
  - Next state is IDLE.
- Poll period with enable held high is exactly POLL_DIV+2 cycles from one avm_read pulse to the next.
- Change detection in CAP:
  - If primed=0: set last=s and primed=1; no event is generated. This baseline is retaken after reset and after every enable low period.
  - If primed=1 and s!=last: set last=s and push s into the FIFO.
  - If primed=1 and s==last: nothing happens.
- Latency: a change sampled in CAP at cycle N is visible as evt_valid=1 with evt_data=s at cycle N+1, if the FIFO was empty.
- FIFO full:
  - A push when full and no simultaneous pop is dropped and overflow is set. last is still updated to s.
  - A push when full with a pop in the same cycle (evt_valid && evt_ready) is accepted, the count is unchanged, and overflow is not set.
- FIFO empty: evt_ready is ignored and no pop occurs. A push to an empty FIFO appears the next cycle; there is no fall-through.
- Pointers wrap modulo FIFO_DEPTH. The count ranges 0..FIFO_DEPTH.
- overflow:
  - clr_overflow clears it.
  - If set and clear occur in the same cycle, set wins.
- enable deasserted during READ or CAP: the current poll completes normally (the sample is compared and pushed), then the FSM stays in IDLE.
- evt_data holds its value while evt_valid=1 && evt_ready=0.

Decomposition:
- Package pio_poll_pkg holds:
  - the state enum: IDLE, READ, CAP;
  - localparams PIO_DATA_ADDR=0 and READ_LATENCY=1;
  - a function computing the FIFO pointer width.
- Sub-module pio_poll_fifo: synchronous FIFO parameterised on width and depth. Ports: push, push_data, pop, head, empty, full, count. It encapsulates simultaneous push/pop-on-full semantics.
- The top level contains the FSM, counter, primed/last registers and overflow logic.

Test Plan:
1. Reset then enable=1 with POLL_DIV=4 and the slave returning 0x00005 -> avm_read pulses every 6 cycles, address 0. The first sample primes, with no evt_valid; repeated 0x00005 produces no event.
2. Slave value changes 0x00005 -> 0x1ABCD (upper readdata bits 0xFFFE0000 set) with evt_ready=1 -> evt_data=0x1ABCD and evt_valid=1 the cycle after CAP, irq=1 for one cycle, popped the same cycle.
3. evt_ready=0 and 5 distinct changes with FIFO_DEPTH=4 -> first 4 values queued in order and overflow=1 after the 5th. Draining yields the 4 values in order; the next change relative to the 5th value generates an event.
4. FIFO full and a changing sample in CAP with evt_ready=1 in the same cycle -> value accepted, count stays 4, overflow stays 0. Separately, clr_overflow=1 coincident with a dropped push leaves overflow=1.
5. Drop enable during READ -> CAP completes and its change is pushed, then there are no further avm_read pulses. On re-enable the first poll re-primes, so a value differing from last generates no event.
6. Assert reset_n=0 in CAP with 2 queued events -> evt_valid, irq and overflow are 0 immediately and avm_read=0. After release the FSM restarts from IDLE with counter=0.

Source files
------------

// File: rtl/pio_poll_pkg.sv
// Shared types and constants for the PIO change-polling master.
package pio_poll_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    CAP  = 2'd2
  } state_e;

  localparam int PIO_DATA_ADDR = 32'sd0;
  localparam int READ_LATENCY  = 32'sd1;

  function automatic int fifo_ptr_w(input int depth);
    return (depth > 32'sd1) ? $clog2(depth) : 32'sd1;
  endfunction

endpackage

// File: rtl/pio_poll_fifo.sv
// Small synchronous event FIFO; a push while full is accepted only when a pop
// frees the head slot in the same cycle.
module pio_poll_fifo
  import pio_poll_pkg::*;
#(
  parameter  int WIDTH = 17,
  parameter  int DEPTH = 4,
  localparam int PTR_W = fifo_ptr_w(DEPTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             empty,
  output logic             full,
  output logic [PTR_W:0]   count
);

  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             do_push_s;
  logic             do_pop_s;

  // Accept/reject decisions and next pointer/occupancy values.
  always_comb begin
    do_pop_s  = pop && (count_q != {(PTR_W + 1){1'b0}});
    do_push_s = push && ((count_q != FULL_CNT) || do_pop_s);
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    if (do_push_s) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1'b1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (do_pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1'b1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({do_push_s, do_pop_s})
      2'b10:   count_d = count_q + (PTR_W + 1)'(1'b1);
      2'b01:   count_d = count_q - (PTR_W + 1)'(1'b1);
      default: count_d = count_q;
    endcase
  end

  // Storage, pointers and occupancy; reset flushes every entry.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {WIDTH{1'b0}};
      end
      wr_ptr_q <= {PTR_W{1'b0}};
      rd_ptr_q <= {PTR_W{1'b0}};
      count_q  <= {(PTR_W + 1){1'b0}};
    end else begin
      if (do_push_s) begin
        mem_q[wr_ptr_q] <= push_data;
      end
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign empty = (count_q == {(PTR_W + 1){1'b0}});
  assign full  = (count_q == FULL_CNT);
  assign count = count_q;

endmodule

// File: rtl/pio_poll_master.sv
// Avalon-MM master that polls a PIO input at address 0 and streams each
// changed value through an event FIFO with a level interrupt.
module pio_poll_master
  import pio_poll_pkg::*;
#(
  parameter int DATA_W     = 17,
  parameter int ADDR_W     = 2,
  parameter int POLL_DIV   = 1000,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              enable,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_read,
  input  logic [31:0]       avm_readdata,
  output logic [DATA_W-1:0] evt_data,
  output logic              evt_valid,
  input  logic              evt_ready,
  output logic              irq,
  output logic              overflow,
  input  logic              clr_overflow
);

  localparam int CNT_W    = (POLL_DIV > 32'sd1) ? $clog2(POLL_DIV) : 32'sd1;
  localparam int LAST_CNT = POLL_DIV - 32'sd1;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              primed_q, primed_d;
  logic [DATA_W-1:0] last_q, last_d;
  logic              overflow_q, overflow_d;
  logic              avm_read_q, avm_read_d;

  logic [DATA_W-1:0] sample_s;
  logic              push_s;
  logic              pop_s;
  logic              fifo_empty_s;
  logic              fifo_full_s;
  logic [DATA_W-1:0] fifo_head_s;
  logic [fifo_ptr_w(FIFO_DEPTH):0] fifo_count_unused_s;
  logic              unused_readdata_s;

  // Upper readdata bits are outside the sampled field.
  assign unused_readdata_s = ^avm_readdata;
  assign sample_s          = avm_readdata[DATA_W-1:0];

  // Poll sequencing, change detection and overflow bookkeeping.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    primed_d   = primed_q;
    last_d     = last_q;
    push_s     = 1'b0;
    case (state_q)
      IDLE: begin
        if (enable) begin
          if (cnt_q == CNT_W'(LAST_CNT)) begin
            state_d = READ;
            cnt_d   = {CNT_W{1'b0}};
          end else begin
            cnt_d = cnt_q + CNT_W'(1'b1);
          end
        end else begin
          // Disabled: the next poll after re-enable retakes the baseline.
          cnt_d    = {CNT_W{1'b0}};
          primed_d = 1'b0;
        end
      end
      READ: begin
        state_d = CAP;
      end
      CAP: begin
        state_d = IDLE;
        if (!primed_q) begin
          last_d   = sample_s;
          primed_d = 1'b1;
        end else if (sample_s != last_q) begin
          last_d = sample_s;
          push_s = 1'b1;
        end else begin
          last_d = last_q;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = {CNT_W{1'b0}};
      end
    endcase

    avm_read_d = (state_d == READ);
    pop_s      = evt_ready && !fifo_empty_s;

    if (push_s && fifo_full_s && !pop_s) begin
      overflow_d = 1'b1;
    end else if (clr_overflow) begin
      overflow_d = 1'b0;
    end else begin
      overflow_d = overflow_q;
    end
  end

  // Control and status registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      cnt_q      <= {CNT_W{1'b0}};
      primed_q   <= 1'b0;
      last_q     <= {DATA_W{1'b0}};
      overflow_q <= 1'b0;
      avm_read_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      primed_q   <= primed_d;
      last_q     <= last_d;
      overflow_q <= overflow_d;
      avm_read_q <= avm_read_d;
    end
  end

  pio_poll_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (push_s),
    .push_data (sample_s),
    .pop       (pop_s),
    .head      (fifo_head_s),
    .empty     (fifo_empty_s),
    .full      (fifo_full_s),
    .count     (fifo_count_unused_s)
  );

  assign avm_address = ADDR_W'(PIO_DATA_ADDR);
  assign avm_read    = avm_read_q;
  assign evt_data    = fifo_head_s;
  assign evt_valid   = !fifo_empty_s;
  assign irq         = !fifo_empty_s;
  assign overflow    = overflow_q;

endmodule
